// File: rtl/req_burst_ctrl_if.sv
// Burst-request bundle between the four agents, this controller and the arbiter.
// Latency: none (wiring only).
// Backpressure: none here; grants from the arbiter pace the bursts.
// Ports: start/len per agent (commands), gnt per agent (arbiter grants),
//        req/busy/done/tmo per agent plus prot_err (controller status).
interface req_burst_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             start_0, start_1, start_2, start_3;
    logic [LEN_W-1:0] len_0, len_1, len_2, len_3;
    logic             gnt_0, gnt_1, gnt_2, gnt_3;
    logic             req_0, req_1, req_2, req_3;
    logic             busy_0, busy_1, busy_2, busy_3;
    logic             done_0, done_1, done_2, done_3;
    logic             tmo_0, tmo_1, tmo_2, tmo_3;
    logic             prot_err;

    // Agent/arbiter side: issues commands and grants, observes status.
    modport master (
        output start_0, start_1, start_2, start_3,
        output len_0, len_1, len_2, len_3,
        output gnt_0, gnt_1, gnt_2, gnt_3,
        input  req_0, req_1, req_2, req_3,
        input  busy_0, busy_1, busy_2, busy_3,
        input  done_0, done_1, done_2, done_3,
        input  tmo_0, tmo_1, tmo_2, tmo_3,
        input  prot_err
    );

    // Controller side.
    modport slave (
        input  start_0, start_1, start_2, start_3,
        input  len_0, len_1, len_2, len_3,
        input  gnt_0, gnt_1, gnt_2, gnt_3,
        output req_0, req_1, req_2, req_3,
        output busy_0, busy_1, busy_2, busy_3,
        output done_0, done_1, done_2, done_3,
        output tmo_0, tmo_1, tmo_2, tmo_3,
        output prot_err
    );
endinterface

// File: rtl/req_burst_ctrl.sv
// Turns one-cycle burst commands from four agents into level requests, counts granted beats.
// Latency: all outputs registered; req rises the edge after start, falls on the last-beat edge.
// Backpressure: a missing grant stalls the burst; TMO_MAX ungranted WAIT edges abort it.
// Ports: clock, reset (async active-low), bus (slave modport of req_burst_ctrl_if).
module req_burst_ctrl #(
    parameter int LEN_W   = 4,
    parameter int TMO_W   = 5,
    parameter int TMO_MAX = 20
) (
    input  logic             clock,
    input  logic             reset,
    req_burst_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TMO_MAX);

    logic [3:0]       start_v;
    logic [3:0]       gnt_v;
    logic [LEN_W-1:0] len_v [4];
    logic [3:0]       req_v, busy_v, done_v, tmo_v;
    logic [3:0]       idle_v;
    logic             prot_q;

    assign start_v  = {bus.start_3, bus.start_2, bus.start_1, bus.start_0};
    assign gnt_v    = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
    assign len_v[0] = bus.len_0;
    assign len_v[1] = bus.len_1;
    assign len_v[2] = bus.len_2;
    assign len_v[3] = bus.len_3;

    for (genvar g = 0; g < 4; g++) begin : g_agent
        state_t           state_q, state_d;
        logic [LEN_W-1:0] len_q, len_d;
        logic [LEN_W-1:0] beat_q, beat_d;
        logic [TMO_W-1:0] wait_q, wait_d;
        logic             req_q, busy_q, done_q, tmo_q;
        logic             abort;
        logic [LEN_W-1:0] beat_inc;
        logic [TMO_W-1:0] wait_inc;

        // beat_q < len_q whenever a beat is counted, so the increment never wraps.
        assign beat_inc = beat_q + LEN_ONE;
        assign wait_inc = wait_q + TMO_ONE;

        always_comb begin
            state_d = state_q;
            len_d   = len_q;
            beat_d  = beat_q;
            wait_d  = wait_q;
            abort   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_v[g] && (len_v[g] != LEN_ZERO)) begin
                        state_d = WAIT;
                        len_d   = len_v[g];
                        beat_d  = '0;
                        wait_d  = '0;
                    end
                end
                WAIT: begin
                    if (gnt_v[g]) begin
                        beat_d  = beat_inc;
                        state_d = (beat_inc == len_q) ? DONE : XFER;
                    end else begin
                        wait_d = wait_inc;
                        if (wait_inc == TMO_LIM) begin
                            state_d = IDLE;
                            abort   = 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (gnt_v[g]) begin
                        beat_d = beat_inc;
                        if (beat_inc == len_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        // Preempted: keep beats, restart the wait window.
                        state_d = WAIT;
                        wait_d  = '0;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are registered copies of what the next state implies,
        // so they change on the same edge as the state.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                len_q   <= '0;
                beat_q  <= '0;
                wait_q  <= '0;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                len_q   <= len_d;
                beat_q  <= beat_d;
                wait_q  <= wait_d;
                req_q   <= (state_d == WAIT) || (state_d == XFER);
                busy_q  <= (state_d != IDLE);
                done_q  <= (state_d == DONE);
                tmo_q   <= abort;
            end
        end

        assign idle_v[g] = (state_q == IDLE);
        assign req_v[g]  = req_q;
        assign busy_v[g] = busy_q;
        assign done_v[g] = done_q;
        assign tmo_v[g]  = tmo_q;
    end

    // Grants to an idle agent, or more than one grant at once, latch the error.
    // x & (x-1) clears the lowest set bit, so a nonzero result means two or more grants.
    logic multi_gnt;
    logic prot_hit;
    assign multi_gnt = |(gnt_v & (gnt_v - 4'd1));
    assign prot_hit  = multi_gnt || (|(gnt_v & idle_v));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prot_q <= 1'b0;
        end else if (prot_hit) begin
            prot_q <= 1'b1;
        end
    end

    assign bus.req_0    = req_v[0];
    assign bus.req_1    = req_v[1];
    assign bus.req_2    = req_v[2];
    assign bus.req_3    = req_v[3];
    assign bus.busy_0   = busy_v[0];
    assign bus.busy_1   = busy_v[1];
    assign bus.busy_2   = busy_v[2];
    assign bus.busy_3   = busy_v[3];
    assign bus.done_0   = done_v[0];
    assign bus.done_1   = done_v[1];
    assign bus.done_2   = done_v[2];
    assign bus.done_3   = done_v[3];
    assign bus.tmo_0    = tmo_v[0];
    assign bus.tmo_1    = tmo_v[1];
    assign bus.tmo_2    = tmo_v[2];
    assign bus.tmo_3    = tmo_v[3];
    assign bus.prot_err = prot_q;

endmodule

// File: tb/tb_req_burst_ctrl.sv
// Self-checking bench for req_burst_ctrl: vector table, directed corner sequences, random traffic.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: a bench-side arbiter drives grants from the reference model's requests.
module tb_req_burst_ctrl;

    localparam int TMO_MAX = 20;

    logic clock;
    logic reset;
    logic       st [4];
    logic [3:0] ln [4];
    logic       gn [4];

    int n_checks = 0;
    int n_fail   = 0;

    req_burst_ctrl_if #(.LEN_W(4)) bus ();

    assign bus.start_0 = st[0];
    assign bus.start_1 = st[1];
    assign bus.start_2 = st[2];
    assign bus.start_3 = st[3];
    assign bus.len_0   = ln[0];
    assign bus.len_1   = ln[1];
    assign bus.len_2   = ln[2];
    assign bus.len_3   = ln[3];
    assign bus.gnt_0   = gn[0];
    assign bus.gnt_1   = gn[1];
    assign bus.gnt_2   = gn[2];
    assign bus.gnt_3   = gn[3];

    req_burst_ctrl #(.LEN_W(4), .TMO_W(5), .TMO_MAX(TMO_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Per agent: is a burst requesting, beats still owed, ungranted edges in the
    // current wait window, whether the previous edge was granted, and the
    // one-cycle completion / abort flags.
    bit m_act  [4];
    bit m_fin  [4];
    bit m_tmo  [4];
    bit m_lastg[4];
    int m_left [4];
    int m_stall[4];
    bit m_prot;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_fin[i] = 0; m_tmo[i] = 0;
            m_lastg[i] = 0; m_left[i] = 0; m_stall[i] = 0;
        end
        m_prot = 0;
    endfunction

    function automatic void model_step();
        int ng = 0;
        for (int i = 0; i < 4; i++) begin
            if (gn[i]) ng++;
            if (gn[i] && !m_act[i] && !m_fin[i]) m_prot = 1;
        end
        if (ng > 1) m_prot = 1;
        for (int i = 0; i < 4; i++) begin
            m_tmo[i] = 0;
            if (m_fin[i]) begin
                m_fin[i] = 0;
            end else if (!m_act[i]) begin
                if (st[i] && ln[i] != 0) begin
                    m_act[i]   = 1;
                    m_left[i]  = int'(ln[i]);
                    m_stall[i] = 0;
                    m_lastg[i] = 0;
                end
            end else if (gn[i]) begin
                m_left[i]--;
                m_lastg[i] = 1;
                if (m_left[i] == 0) begin
                    m_act[i] = 0;
                    m_fin[i] = 1;
                end
            end else begin
                // First ungranted edge after a grant only reopens the window.
                if (m_lastg[i]) begin
                    m_stall[i] = 0;
                    m_lastg[i] = 0;
                end else begin
                    m_stall[i]++;
                end
                if (m_stall[i] == TMO_MAX) begin
                    m_act[i] = 0;
                    m_tmo[i] = 1;
                end
            end
        end
    endfunction

    function automatic logic [16:0] model_out();
        logic [3:0] r, b, d, t;
        for (int i = 0; i < 4; i++) begin
            r[i] = m_act[i];
            b[i] = m_act[i] | m_fin[i];
            d[i] = m_fin[i];
            t[i] = m_tmo[i];
        end
        return {m_prot, t, d, b, r};
    endfunction

    function automatic logic [16:0] dut_out();
        return {bus.prot_err,
                bus.tmo_3,  bus.tmo_2,  bus.tmo_1,  bus.tmo_0,
                bus.done_3, bus.done_2, bus.done_1, bus.done_0,
                bus.busy_3, bus.busy_2, bus.busy_1, bus.busy_0,
                bus.req_3,  bus.req_2,  bus.req_1,  bus.req_0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            st[i] = 0; ln[i] = 0; gn[i] = 0;
        end
    endtask

    // One clock: advance the model on the same inputs, then compare after the edge.
    task automatic tick(input string name);
        model_step();
        @(posedge clock);
        #1;
        chk(name, 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("reset_state", 32'(dut_out()), 32'd0);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  start;
        logic [15:0] len;   // {len3,len2,len1,len0}
        logic [3:0]  gnt;
        logic [3:0]  req;
        logic [3:0]  busy;
        logic [3:0]  done;
        logic        prot;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int beats;
        int done_seen;
        logic [3:0] pick;
        int np;

        // Single burst, agent 0, len 3, ideal arbiter (gnt one edge behind req).
        tbl[0]  = '{4'b0001, 16'h0003, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 16'h0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 16'h0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0000, 16'h0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 16'h0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0};
        tbl[5]  = '{4'b0000, 16'h0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        // Agent 2: zero length ignored; restart during a burst ignored.
        tbl[7]  = '{4'b0100, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0100, 16'h0200, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0100, 16'h0500, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 16'h0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0};
        tbl[11] = '{4'b0000, 16'h0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        clear_inputs();
        do_reset();

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) begin
                st[i] = tbl[r].start[i];
                ln[i] = tbl[r].len[4*i +: 4];
                gn[i] = tbl[r].gnt[i];
            end
            tick($sformatf("tbl%0d_model", r));
            chk($sformatf("tbl%0d_vec", r), 32'(dut_out()),
                32'({tbl[r].prot, 4'b0000, tbl[r].done, tbl[r].busy, tbl[r].req}));
        end
        clear_inputs();

        // Timeout: agent 1, len 2, never granted.
        do_reset();
        st[1] = 1; ln[1] = 4'd2;
        tick("tmo_start");
        st[1] = 0; ln[1] = 0;
        done_seen = 0;
        for (int k = 1; k <= TMO_MAX; k++) begin
            tick("tmo_wait");
            if (bus.done_1) done_seen++;
            if (k == TMO_MAX - 1) chk("tmo_req_before_limit", 32'(bus.req_1), 32'd1);
        end
        chk("tmo_req_dropped", 32'(bus.req_1), 32'd0);
        chk("tmo_pulse", 32'(bus.tmo_1), 32'd1);
        chk("tmo_busy_low", 32'(bus.busy_1), 32'd0);
        tick("tmo_after");
        if (bus.done_1) done_seen++;
        chk("tmo_pulse_once", 32'(bus.tmo_1), 32'd0);
        chk("tmo_no_done", 32'(done_seen), 32'd0);

        // Preemption: agent 3, len 4: one beat, three ungranted edges, three beats.
        do_reset();
        st[3] = 1; ln[3] = 4'd4;
        tick("pre_start");
        st[3] = 0; ln[3] = 0;
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            gn[3] = (k == 0 || k >= 4);
            if (gn[3] && bus.req_3) beats++;
            chk("pre_req_held", 32'(bus.req_3), 32'd1);
            tick("pre_step");
        end
        gn[3] = 0;
        chk("pre_beats", 32'(beats), 32'd4);
        chk("pre_done", 32'(bus.done_3), 32'd1);
        tick("pre_idle");

        // Protocol error: grant to an idle agent, sticky.
        do_reset();
        gn[1] = 1;
        tick("prot_idle");
        chk("prot_idle_set", 32'(bus.prot_err), 32'd1);
        gn[1] = 0;
        tick("prot_sticky");
        tick("prot_sticky2");
        chk("prot_stays", 32'(bus.prot_err), 32'd1);

        // Protocol error: two active agents granted together.
        do_reset();
        st[0] = 1; ln[0] = 4'd5; st[2] = 1; ln[2] = 4'd5;
        tick("multi_start");
        clear_inputs();
        tick("multi_wait");
        chk("multi_no_err_yet", 32'(bus.prot_err), 32'd0);
        gn[0] = 1; gn[2] = 1;
        tick("multi_gnt");
        chk("multi_err", 32'(bus.prot_err), 32'd1);
        clear_inputs();

        // Reset mid-burst while agent 0 is in XFER.
        do_reset();
        st[0] = 1; ln[0] = 4'd5;
        tick("rst_start");
        st[0] = 0; ln[0] = 0; gn[0] = 1;
        tick("rst_beat1");
        gn[1] = 1;
        tick("rst_beat2");
        chk("rst_pre_prot", 32'(bus.prot_err), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", 32'({bus.prot_err, bus.busy_0, bus.req_0}), 32'd0);
        clear_inputs();
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick("rst_after");
            if (bus.done_0) done_seen++;
        end
        chk("rst_no_done", 32'(done_seen), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                ln[i] = 4'($urandom_range(0, 6));
                gn[i] = 0;
            end
            pick = '0;
            np = 0;
            for (int i = 0; i < 4; i++) if (m_act[i]) np++;
            if (np > 0 && $urandom_range(0, 4) != 0) begin
                int sel = $urandom_range(0, np - 1);
                for (int i = 0; i < 4; i++) begin
                    if (m_act[i]) begin
                        if (sel == 0) pick[i] = 1'b1;
                        sel--;
                    end
                end
            end
            if ($urandom_range(0, 199) == 0) pick = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) gn[i] = pick[i];
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_burst_ctrl.md
Name: req_burst_ctrl

Overview:
- Request-side controller that sits directly upstream of the 4-agent arbiter FSM (fsm_full).
- Converts one-cycle burst commands from four agents into level requests req_0..req_3, and counts granted beats per agent.
- Drops each request after the commanded burst length, or on a wait timeout.
- Reports per-agent busy, done and timeout, plus a sticky protocol-error flag on the returned grants.

Parameters:
- LEN_W, 4, width of burst-length inputs; max burst = 2^LEN_W-1 beats.
- TMO_W, 5, width of the grant-wait timeout counter.
- TMO_MAX, 20, cycles in WAIT without a grant before abort; must fit TMO_W.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start_0..start_3  in  1 each  one-cycle burst command per agent.
- len_0..len_3  in  LEN_W each  burst length, sampled with start_i.
- gnt_0..gnt_3  in  1 each  grants returned by the arbiter.
- req_0..req_3  out  1 each  registered level requests to the arbiter.
- busy_0..busy_3  out  1 each  high while agent i is not IDLE.
- done_0..done_3  out  1 each  one-cycle pulse, burst completed.
- tmo_0..tmo_3  out  1 each  one-cycle pulse, burst aborted by timeout.
- prot_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0) clears immediately, without waiting for a clock edge: all states to IDLE, counters to 0, and all req, busy, done, tmo and prot_err to 0. Reset mid-burst drops req at once; the burst is lost with no done.
- Four independent per-agent FSMs, identical. All outputs are registered.
- IDLE:
  - start_i=1 with len_i!=0 -> WAIT. Latch len_i, beat counter=0, wait counter=0.
  - start_i with len_i=0 is ignored.
  - start_i while not IDLE is ignored; the latched length is unchanged.
- WAIT (req_i=1):
  - Edge with gnt_i=1 counts one beat. If beats==len -> DONE, else -> XFER.
  - Edge with gnt_i=0: wait counter +1. On reaching TMO_MAX -> IDLE with req_i=0 and a tmo_i pulse in the following cycle.
- XFER (req_i=1):
  - Each edge with gnt_i=1 counts one beat. On the last beat -> DONE.
  - Edge with gnt_i=0 (preempted) -> WAIT. Beat count is kept; wait counter is reset to 0.
- DONE (req_i=0, done_i=1): one cycle, then -> IDLE.
  - A gnt_i still high in DONE is legal: it is the arbiter's one-cycle release latency.
- Output timing: req_i, busy_i, done_i and tmo_i all change on the edge that changes state.
  - busy_i=1 in WAIT, XFER and DONE.
  - tmo_i is high for the one cycle after the abort edge; busy_i is 0 in that same cycle.
- prot_err is set at an edge when either:
  - any gnt_i=1 while agent i is IDLE, or
  - more than one gnt is high at once.
  - It clears only on reset.
- Beat arithmetic: the beat counter is LEN_W bits, compared against the latched length, so it never wraps.
- Simultaneous events: beat counting and timeout are exclusive, since a timeout edge requires gnt_i=0. Agents are fully independent; arbitration priority belongs to the arbiter, not this block.

Test Plan:
- Single burst: start_0 with len_0=3 at edge 0 (ideal arbiter: gnt follows req one edge later).
  - Required: req_0 rises after edge 0 and gnt_0 after edge 1.
  - Beats are counted at edges 2, 3 and 4, so req_0 falls and done_0=1 after edge 4.
  - busy_0 falls after edge 5; prot_err stays 0.
- Timeout: start_1 with len_1=2 and gnt_1 held 0.
  - Required: req_1 falls after 20 WAIT edges, tmo_1 pulses once, done_1 never asserts.
- Preemption: agent 3 granted 1 beat of len_3=4, then gnt_3 dropped for 3 cycles, then restored.
  - Required: req_3 stays high throughout, exactly 4 granted beats in total, then done_3.
- Rejections:
  - start_2 with len_2=0 -> no req_2 and no busy_2.
  - A second start_2 during an active burst -> ignored; the burst ends at the original length.
- Protocol error:
  - gnt_1 forced high while agent 1 is IDLE -> prot_err=1 and it stays 1.
  - gnt_0 and gnt_2 high together -> prot_err=1.
- Reset mid-burst: drive reset=0 between edges while agent 0 is in XFER.
  - Required: req_0, busy_0 and prot_err go 0 immediately, with no done_0 afterwards.
